// File: rtl/ex_wb_regfile.sv
// EX/WB stage register feeding a register file with two forwarding read ports.
// Also counts committed register writes.
module ex_wb_regfile #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [4:0]        ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              re1_i,
    input  logic [4:0]        raddr1_i,
    input  logic              re2_i,
    input  logic [4:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [4:0]        wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [31:0]       commit_cnt_o
);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [4:0]        wb_wd_q, wb_wd_d;
    logic              wb_wreg_q, wb_wreg_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
    logic [31:0]       commit_cnt_q;
    logic              commit;

    // A stalled entry is consumed by its commit, so it cannot commit twice.
    always_comb begin
        wb_wd_d    = ex_wd_i;
        wb_wreg_d  = ex_wreg_i;
        wb_wdata_d = ex_wdata_i;
        if (flush_i) begin
            wb_wd_d    = '0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = '0;
        end else if (stall_i) begin
            wb_wd_d    = wb_wd_q;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = wb_wdata_q;
        end
    end

    assign commit = wb_wreg_q && (wb_wd_q != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= '0;
            end
            wb_wd_q      <= '0;
            wb_wreg_q    <= 1'b0;
            wb_wdata_q   <= '0;
            commit_cnt_q <= '0;
        end else begin
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            if (commit) begin
                regs_q[wb_wd_q] <= wb_wdata_q;
                commit_cnt_q    <= commit_cnt_q + 32'd1;
            end
        end
    end

    // Youngest producer wins: EX result over stage contents over the file.
    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!rst || !re || addr == 5'd0) begin
            val = '0;
        end else if (ex_wreg_i && ex_wd_i == addr) begin
            val = ex_wdata_i;
        end else if (wb_wreg_q && wb_wd_q == addr) begin
            val = wb_wdata_q;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i);
        rdata2_o = read_port(re2_i, raddr2_i);
    end

    assign wb_wd_o      = wb_wd_q;
    assign wb_wreg_o    = wb_wreg_q;
    assign wb_wdata_o   = wb_wdata_q;
    assign commit_cnt_o = commit_cnt_q;

endmodule

// File: tb/tb_ex_wb_regfile.sv
// Directed bench for ex_wb_regfile: forwarding, commit count, stall/flush,
// x0 handling, count wrap and asynchronous reset.
module tb_ex_wb_regfile;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic [31:0] commit_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_wb_regfile #(
        .DATA_W (32),
        .REG_NUM(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ex_wd_i     (ex_wd_i),
        .ex_wreg_i   (ex_wreg_i),
        .ex_wdata_i  (ex_wdata_i),
        .re1_i       (re1_i),
        .raddr1_i    (raddr1_i),
        .re2_i       (re2_i),
        .raddr2_i    (raddr2_i),
        .rdata1_o    (rdata1_o),
        .rdata2_o    (rdata2_o),
        .wb_wd_o     (wb_wd_o),
        .wb_wreg_o   (wb_wreg_o),
        .wb_wdata_o  (wb_wdata_o),
        .commit_cnt_o(commit_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic wreg, input logic [4:0] wd, input logic [31:0] data);
        ex_wreg_i  = wreg;
        ex_wd_i    = wd;
        ex_wdata_i = data;
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        ex_drive(1'b0, 5'd0, 32'd0);
        re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b0; raddr2_i = 5'd5;
        tick(); tick();
        chk("reset_wb_wreg", {31'd0, wb_wreg_o}, 32'd0);
        chk("reset_wb_wd", {27'd0, wb_wd_o}, 32'd0);
        chk("reset_wb_wdata", wb_wdata_o, 32'd0);
        chk("reset_cnt", commit_cnt_o, 32'd0);
        ex_drive(1'b1, 5'd5, 32'h1234_5678);
        #1 chk("reset_rdata1", rdata1_o, 32'd0);
        ex_drive(1'b0, 5'd0, 32'd0);
        rst = 1'b1;

        // Writeback x5
        ex_drive(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1 chk("wb_fwd_ex", rdata1_o, 32'hDEAD_BEEF);
        chk("wb_re2_off", rdata2_o, 32'd0);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        #1 chk("wb_stage_wd", {27'd0, wb_wd_o}, 32'd5);
        chk("wb_stage_wreg", {31'd0, wb_wreg_o}, 32'd1);
        chk("wb_fwd_stage", rdata1_o, 32'hDEAD_BEEF);
        chk("wb_cnt0", commit_cnt_o, 32'd0);
        tick();
        chk("wb_cnt1", commit_cnt_o, 32'd1);
        chk("wb_regfile", rdata1_o, 32'hDEAD_BEEF);
        chk("wb_stage_idle", {31'd0, wb_wreg_o}, 32'd0);

        // Forward priority on x3
        ex_drive(1'b1, 5'd3, 32'h11);
        tick();
        ex_drive(1'b1, 5'd3, 32'h22);
        re2_i = 1'b1; raddr2_i = 5'd3; raddr1_i = 5'd3;
        #1 chk("fwd_ex_over_stage", rdata2_o, 32'h22);
        chk("fwd_same_addr_p1", rdata1_o, 32'h22);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        #1 chk("fwd_stage", rdata2_o, 32'h22);
        chk("fwd_cnt2", commit_cnt_o, 32'd2);
        tick();
        chk("fwd_regfile", rdata2_o, 32'h22);
        chk("fwd_cnt3", commit_cnt_o, 32'd3);

        // x0 writes are ignored
        ex_drive(1'b1, 5'd0, 32'hFFFF);
        raddr1_i = 5'd0;
        #1 chk("x0_ex", rdata1_o, 32'd0);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        #1 chk("x0_stage", rdata1_o, 32'd0);
        tick();
        chk("x0_after", rdata1_o, 32'd0);
        chk("x0_cnt", commit_cnt_o, 32'd3);

        // Stall: x7 commits once across three stalled cycles
        ex_drive(1'b1, 5'd7, 32'h7);
        tick();
        stall_i = 1'b1;
        ex_drive(1'b1, 5'd9, 32'h9);
        raddr1_i = 5'd7;
        #1 chk("stall_fwd", rdata1_o, 32'h7);
        tick();
        chk("stall_cnt_a", commit_cnt_o, 32'd4);
        chk("stall_wreg", {31'd0, wb_wreg_o}, 32'd0);
        chk("stall_hold_wd", {27'd0, wb_wd_o}, 32'd7);
        chk("stall_hold_data", wb_wdata_o, 32'h7);
        chk("stall_regfile", rdata1_o, 32'h7);
        tick(); tick();
        chk("stall_cnt_b", commit_cnt_o, 32'd4);
        ex_drive(1'b0, 5'd0, 32'd0);
        stall_i = 1'b0;

        // Flush wins over stall
        ex_drive(1'b1, 5'd8, 32'h8);
        flush_i = 1'b1; stall_i = 1'b1;
        tick();
        chk("flush_wreg", {31'd0, wb_wreg_o}, 32'd0);
        chk("flush_wd", {27'd0, wb_wd_o}, 32'd0);
        chk("flush_data", wb_wdata_o, 32'd0);
        ex_drive(1'b0, 5'd0, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0;
        raddr1_i = 5'd8;
        tick();
        chk("flush_x8", rdata1_o, 32'd0);
        chk("flush_cnt", commit_cnt_o, 32'd4);

        // Commit count wrap
        force dut.commit_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.commit_cnt_q;
        chk("wrap_pre", commit_cnt_o, 32'hFFFF_FFFF);
        ex_drive(1'b1, 5'd10, 32'hA);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("wrap_cnt", commit_cnt_o, 32'd0);
        raddr1_i = 5'd10;
        #1 chk("wrap_x10", rdata1_o, 32'hA);

        // Asynchronous reset mid-stall
        ex_drive(1'b1, 5'd12, 32'hC);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        stall_i = 1'b1;
        raddr1_i = 5'd5; raddr2_i = 5'd3;
        #2 rst = 1'b0;
        #1 chk("arst_wreg", {31'd0, wb_wreg_o}, 32'd0);
        chk("arst_wd", {27'd0, wb_wd_o}, 32'd0);
        chk("arst_data", wb_wdata_o, 32'd0);
        chk("arst_rdata1", rdata1_o, 32'd0);
        chk("arst_rdata2", rdata2_o, 32'd0);
        stall_i = 1'b0;
        tick();
        chk("arst_cnt_held", commit_cnt_o, 32'd0);
        rst = 1'b1;
        #1 chk("arst_x5_cleared", rdata1_o, 32'd0);
        chk("arst_x3_cleared", rdata2_o, 32'd0);
        raddr1_i = 5'd12;
        #1 chk("arst_x12_never", rdata1_o, 32'd0);

        // First edges after release behave normally
        ex_drive(1'b1, 5'd4, 32'h44);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        chk("post_stage_wd", {27'd0, wb_wd_o}, 32'd4);
        chk("post_cnt0", commit_cnt_o, 32'd0);
        tick();
        chk("post_cnt1", commit_cnt_o, 32'd1);
        raddr1_i = 5'd4;
        #1 chk("post_x4", rdata1_o, 32'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_wb_regfile.md
EX_WB_REGFILE -- requirements
Module: ex_wb_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register and data width in bits.
REQ-002 The block SHALL have parameter REG_NUM, default 32, meaning the number of architectural registers; addresses are log2(REG_NUM)=5 bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-005 The block SHALL have port stall_i  input  1  hold request for the EX/WB stage register.
REQ-006 The block SHALL have port flush_i  input  1  squash request for the EX/WB stage register.
REQ-007 The block SHALL have port ex_wd_i  input  5  EX destination register address.
REQ-008 The block SHALL have port ex_wreg_i  input  1  EX write-enable.
REQ-009 The block SHALL have port ex_wdata_i  input  DATA_W  EX result data.
REQ-010 The block SHALL have ports re1_i / re2_i  input  1  read-port enables.
REQ-011 The block SHALL have ports raddr1_i / raddr2_i  input  5  read-port addresses.
REQ-012 The block SHALL have ports rdata1_o / rdata2_o  output  DATA_W  read-port data, combinational.
REQ-013 The block SHALL have ports wb_wd_o (5), wb_wreg_o (1), wb_wdata_o (DATA_W)  output  stage-register contents.
REQ-014 The block SHALL have port commit_cnt_o  output  32  count of committed register writes.

Function
REQ-015 Stage register update at each rising clk edge, flush_i priority over stall_i:
- flush_i=1: wb_wreg_o<=0, wb_wd_o<=0, wb_wdata_o<=0.
- else stall_i=1: wb_wd_o and wb_wdata_o hold; wb_wreg_o<=0 (entry consumed).
- else: capture ex_wd_i, ex_wreg_i, ex_wdata_i.
REQ-016 Commit: at each rising edge, if pre-edge wb_wreg_o=1 and wb_wd_o!=0, regs[wb_wd_o]<=wb_wdata_o and commit_cnt_o increments by 1; the commit happens regardless of stall_i/flush_i on that edge.
REQ-017 Register 0 SHALL never be written, reads of it SHALL return 0, and writes targeting it SHALL not increment commit_cnt_o.
REQ-018 Latency: an EX result presented at edge N (unstalled, unflushed) is in the stage register after edge N and in the register file after edge N+1; it is forwarded on reads in every intervening cycle.
REQ-019 Each read port SHALL select, in priority order:
- rst=0 -> 0;
- re=0 -> 0;
- raddr=0 -> 0;
- ex_wreg_i=1 and ex_wd_i=raddr -> ex_wdata_i;
- wb_wreg_o=1 and wb_wd_o=raddr -> wb_wdata_o;
- else regs[raddr].
REQ-020 EX and stage targeting the same register simultaneously SHALL forward ex_wdata_i (youngest wins).
REQ-021 Both read ports SHALL operate independently, including when reading the same address.
REQ-022 commit_cnt_o SHALL wrap from 0xFFFFFFFF to 0x00000000 without flagging.
REQ-023 A stalled entry SHALL commit exactly once; repeated stall cycles SHALL not re-increment commit_cnt_o.

Reset
REQ-024 Asserting rst=0 at any time, including mid-stall, SHALL immediately clear all registers, the stage register (wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0) and commit_cnt_o=0, with no edge required.
REQ-025 While rst=0, rdata1_o=rdata2_o=0 and no commit SHALL occur.
REQ-026 After rst returns to 1, the first rising edge SHALL behave per REQ-015/016 with no residual state.

Verification
REQ-027 The bench SHALL cover each of the following scenarios:
- Writeback: ex_wd_i=5, ex_wreg_i=1, ex_wdata_i=0xDEADBEEF for one cycle, then idle -> regs[5]=0xDEADBEEF after 2 edges, commit_cnt_o=1; raddr1_i=5, re1_i=1 -> 0xDEADBEEF in every cycle from presentation onward.
- Forward priority: stage holds x3=0x11; EX drives x3=0x22 -> rdata2_o(raddr=3)=0x22; next cycle, EX idle -> 0x22 from stage.
- x0: EX writes x0=0xFFFF -> rdata=0 throughout, commit_cnt_o unchanged.
- Stall/flush: entry x7=0x7 stalled 3 cycles -> single commit, count +1; flush_i and stall_i both high with EX x8=0x8 -> stage cleared, x8 never written.
- Async reset: registers written, rst=0 asserted between edges -> outputs/count 0 before next edge; reads return 0 after release.
- Wrap: preload count 0xFFFFFFFF via 2^32 commits or force, one commit -> 0.
